// File: rtl/imdct_ola_pkg.sv
// Shared types and helpers for the IMDCT overlap-add / pack stage.
// Build option IMDCT_OLA_SAT_EN: saturate the overlap-add sum instead of wrapping it.
package imdct_ola_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_TAIL,
    ST_DONE
  } ola_state_t;

  // Reduce a 17-bit two's-complement sum to one 16-bit output sample.
  function automatic logic [SAMPLE_W-1:0] sat16(input logic [SAMPLE_W:0] sum);
`ifdef IMDCT_OLA_SAT_EN
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      return sum[SAMPLE_W-1:0];
`else
    return sum[SAMPLE_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/imdct_ola_pack_tail.sv
// N x 16 simple dual-port RAM holding the second half of the previous frame.
// One write port, one read port with a single-cycle registered read.
module ola_tail_buf
  import imdct_ola_pkg::*;
#(
  parameter int N  = 256,
  parameter int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [AW-1:0]       i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/imdct_ola_pack.sv
// Overlap-adds each IMDCT frame with the stored tail of the previous one and packs
// two 16-bit samples per 32-bit BRAM write. Build option: IMDCT_OLA_SAT_EN (see package).
module imdct_ola_pack
  import imdct_ola_pkg::*;
#(
  parameter int N           = 256,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                start,
  input  logic                first_frame,
  input  logic [WORD_W-1:0]   base_addr,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                intr_clr,
  output logic                intr,
  output logic                err,
  output logic [WORD_W-1:0]   bram_addra,
  output logic [WORD_W-1:0]   bram_dina,
  output logic [3:0]          bram_wea,
  output logic                bram_ena,
  output logic                bram_rsta
);

  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(2 * N) + 1;
  localparam int WIW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0]  HEAD_END = CW'(N - 1);
  localparam logic [CW-1:0]  LAST_K   = CW'(2 * N - 1);
  localparam logic [WIW-1:0] WI_MAX   = WIW'(DEPTH_WORDS - 1);

  ola_state_t r_state, w_next;

  logic [CW-1:0]       r_cnt;
  logic                r_armed;
  logic                r_zero_tail;
  logic                r_tail_valid;
  logic [WORD_W-1:0]   r_base;
  logic                r_s1_valid;
  logic                r_s1_odd;
  logic [SAMPLE_W-1:0] r_s1_data;
  logic [SAMPLE_W-1:0] r_lo;
  logic [WIW-1:0]      r_widx;
  logic                r_bram_en;
  logic [WORD_W-1:0]   r_bram_addr;
  logic [WORD_W-1:0]   r_bram_din;
  logic                r_intr;
  logic                r_err;

  logic                w_in_ready;
  logic                w_acc;
  logic                w_is_last;
  logic                w_bad;
  logic                w_start;
  logic                w_done;
  logic                w_head_acc;
  logic                w_tail_we;
  logic [SAMPLE_W-1:0] w_tail_rd;
  logic [SAMPLE_W-1:0] w_addend;
  logic [SAMPLE_W:0]   w_sum17;
  logic [SAMPLE_W-1:0] w_y;
  logic [WORD_W-1:0]   w_word_addr;

  assign w_in_ready = (r_state == ST_HEAD) || (r_state == ST_TAIL);
  assign w_acc      = in_valid && w_in_ready;
  assign w_is_last  = (r_cnt == LAST_K);
  // A framing error is in_last on the wrong sample or missing on the final one.
  assign w_bad      = w_acc && (in_last != w_is_last);
  assign w_start    = start && r_armed && (r_state == ST_IDLE);
  assign w_done     = (r_state == ST_DONE) && !r_s1_valid;
  assign w_head_acc = w_acc && (r_state == ST_HEAD) && !w_bad;
  assign w_tail_we  = w_acc && (r_state == ST_TAIL) && !w_bad;

  assign w_addend    = r_zero_tail ? '0 : w_tail_rd;
  assign w_sum17     = {r_s1_data[SAMPLE_W-1], r_s1_data} + {w_addend[SAMPLE_W-1], w_addend};
  assign w_y         = sat16(w_sum17);
  assign w_word_addr = r_base + {{(WORD_W-WIW-2){1'b0}}, r_widx, 2'b00};

  ola_tail_buf #(.N(N), .AW(AW)) u_tail (
    .clk     (clk_in),
    .i_we    (w_tail_we),
    .i_waddr (r_cnt[AW-1:0]),
    .i_wdata (in_data),
    .i_re    (w_head_acc),
    .i_raddr (r_cnt[AW-1:0]),
    .o_rdata (w_tail_rd)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_HEAD;
      ST_HEAD: begin
        if (w_bad)                          w_next = ST_IDLE;
        else if (w_acc && r_cnt == HEAD_END) w_next = ST_TAIL;
      end
      ST_TAIL: begin
        if (w_bad)                   w_next = ST_IDLE;
        else if (w_acc && w_is_last) w_next = ST_DONE;
      end
      ST_DONE: if (w_done) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-frame context latched at start; start is held off for one cycle after reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_zero_tail <= 1'b1;
      r_base      <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_start) begin
        r_cnt       <= '0;
        r_zero_tail <= first_frame || !r_tail_valid;
        r_base      <= base_addr;
      end else if (w_acc) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_odd   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_head_acc;
      if (w_head_acc) begin
        r_s1_odd  <= r_cnt[0];
        r_s1_data <= in_data;
      end
    end
  end

  // Even samples park in the low half; odd samples complete the word and write it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_lo        <= '0;
      r_widx      <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      r_bram_en <= 1'b0;
      if (r_s1_valid) begin
        if (!r_s1_odd) begin
          r_lo <= w_y;
        end else begin
          r_bram_en   <= 1'b1;
          r_bram_din  <= {w_y, r_lo};
          r_bram_addr <= w_word_addr;
          r_widx      <= (r_widx == WI_MAX) ? '0 : r_widx + WIW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_valid <= 1'b0;
      r_intr       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_bad)        r_tail_valid <= 1'b0;
      else if (w_done)  r_tail_valid <= 1'b1;
      if (w_done)        r_intr <= 1'b1;
      else if (intr_clr) r_intr <= 1'b0;
      if (w_bad)        r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign intr       = r_intr;
  assign err        = r_err;
  assign bram_addra = r_bram_addr;
  assign bram_dina  = r_bram_din;
  assign bram_wea   = {4{r_bram_en}};
  assign bram_ena   = r_bram_en;
  assign bram_rsta  = 1'b0;

endmodule

// File: tb/tb_imdct_ola_pack.sv
// Self-checking bench for imdct_ola_pack (N=4, DEPTH_WORDS=4) with a frame-level reference model.
module tb_imdct_ola_pack;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        start;
  logic        first_frame;
  logic [31:0] base_addr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        intr_clr;
  logic        intr;
  logic        err;
  logic [31:0] bram_addra;
  logic [31:0] bram_dina;
  logic [3:0]  bram_wea;
  logic        bram_ena;
  logic        bram_rsta;

  int testsRun  = 0;
  int failCount = 0;
  int weBad     = 0;

  logic [63:0] gotQ[$];
  logic [63:0] expQ[$];
  logic [15:0] frameData[2*N];
  logic [15:0] refTail[N];
  logic        refTailValid = 1'b0;
  int          refWidx = 0;

  always #5 clk_in = ~clk_in;

  imdct_ola_pack #(.N(N), .DEPTH_WORDS(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .start       (start),
    .first_frame (first_frame),
    .base_addr   (base_addr),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .intr_clr    (intr_clr),
    .intr        (intr),
    .err         (err),
    .bram_addra  (bram_addra),
    .bram_dina   (bram_dina),
    .bram_wea    (bram_wea),
    .bram_ena    (bram_ena),
    .bram_rsta   (bram_rsta)
  );

  always @(negedge clk_in) begin
    if (bram_ena === 1'b1) begin
      gotQ.push_back({bram_addra, bram_dina});
      if (bram_wea !== 4'hF || bram_rsta !== 1'b0) weBad++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One output sample: signed sum of current and previous-tail sample, wrapped or clamped.
  function automatic logic [15:0] olaSample(input logic [15:0] cur, input logic [15:0] prev);
    int s;
    s = int'($signed(cur)) + int'($signed(prev));
`ifdef IMDCT_OLA_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  // abortAt < 0: clean frame; otherwise index of the sample that breaks framing.
  task automatic modelFrame(input logic first, input logic [31:0] base, input int abortAt);
    logic [15:0] p0, p1, y0, y1;
    for (int j = 0; j < N / 2; j++) begin
      if (abortAt >= 0 && 2 * j + 1 >= abortAt) break;
      p0 = (first || !refTailValid) ? 16'h0 : refTail[2*j];
      p1 = (first || !refTailValid) ? 16'h0 : refTail[2*j+1];
      y0 = olaSample(frameData[2*j], p0);
      y1 = olaSample(frameData[2*j+1], p1);
      expQ.push_back({base + 32'(4 * refWidx), y1, y0});
      refWidx = (refWidx + 1) % DEPTH;
    end
    if (abortAt < 0) begin
      for (int i = 0; i < N; i++) refTail[i] = frameData[N+i];
      refTailValid = 1'b1;
    end else begin
      refTailValid = 1'b0;
    end
  endtask

  // lastAt: sample carrying in_last (2N-1 normal, smaller = early, -1 = never).
  task automatic applyStimulus(input logic first, input logic [31:0] base, input int lastAt,
                               input logic clrAtDone, input logic gaps);
    int endIdx;
    int guard;
    if (lastAt == 2 * N - 1)  modelFrame(first, base, -1);
    else if (lastAt < 0)      modelFrame(first, base, 2 * N - 1);
    else                      modelFrame(first, base, lastAt);
    endIdx = (lastAt >= 0 && lastAt < 2 * N - 1) ? lastAt : 2 * N - 1;
    @(negedge clk_in);
    start = 1'b1; first_frame = first; base_addr = base;
    @(negedge clk_in);
    start = 1'b0; first_frame = 1'b0;
    for (int k = 0; k <= endIdx; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_data = 16'($urandom);
          @(negedge clk_in);
        end
      end
      in_valid = 1'b1; in_data = frameData[k]; in_last = (k == lastAt);
      guard = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
        @(negedge clk_in);
        guard++;
      end
      if (guard >= 20) begin
        checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(negedge clk_in);
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (clrAtDone) begin
      intr_clr = 1'b1;
      @(negedge clk_in);
      intr_clr = 1'b0;
    end
    repeat (4) @(negedge clk_in);
  endtask

  task automatic checkFrame(input string tag, input logic expIntr, input logic expErr);
    checkOutput({tag, "_nwrites"}, 64'(gotQ.size()), 64'(expQ.size()));
    while (gotQ.size() > 0 && expQ.size() > 0)
      checkOutput({tag, "_write"}, gotQ.pop_front(), expQ.pop_front());
    gotQ.delete();
    expQ.delete();
    checkOutput({tag, "_intr"}, 64'(intr), 64'(expIntr));
    checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
    checkOutput({tag, "_ready_idle"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_wea"}, 64'(weBad), 64'd0);
    weBad = 0;
  endtask

  task automatic clearIntr(input string tag);
    @(negedge clk_in); intr_clr = 1'b1;
    @(negedge clk_in); intr_clr = 1'b0;
    checkOutput(tag, 64'(intr), 64'd0);
  endtask

  task automatic randomFrame();
    for (int i = 0; i < 2 * N; i++) frameData[i] = 16'($urandom);
  endtask

  task automatic pulseReset();
    @(negedge clk_in); rst_n = 1'b0;
    @(negedge clk_in); rst_n = 1'b1;
    @(negedge clk_in);
    refWidx = 0; refTailValid = 1'b0;
    gotQ.delete();
  endtask

  logic [31:0] satWord;
  logic [31:0] addr0, addr1;

  initial begin
    rst_n = 1'b0; start = 1'b0; first_frame = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; intr_clr = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_flags", {in_ready, intr, err, bram_ena, bram_wea, bram_rsta},
                64'd0);
    checkOutput("reset_bus", {bram_addra, bram_dina}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Test 1: first frame 1..8 at base 0x100
    for (int i = 0; i < 2 * N; i++) frameData[i] = 16'(i + 1);
    applyStimulus(1'b1, 32'h100, 2 * N - 1, 1'b0, 1'b0);
    checkOutput("t1_word0", (gotQ.size() > 0) ? gotQ[0] : 64'hx, 64'h00000100_00020001);
    checkOutput("t1_word1", (gotQ.size() > 1) ? gotQ[1] : 64'hx, 64'h00000104_00040003);
    checkFrame("t1", 1'b1, 1'b0);

    // Test 2: overlap with stored tail 5..8
    for (int i = 0; i < 2 * N; i++) frameData[i] = (i < N) ? 16'd10 : 16'd0;
    applyStimulus(1'b0, 32'h100, 2 * N - 1, 1'b0, 1'b0);
    checkOutput("t2_word0", (gotQ.size() > 0) ? gotQ[0] : 64'hx, 64'h00000108_0010000F);
    checkOutput("t2_word1", (gotQ.size() > 1) ? gotQ[1] : 64'hx, 64'h0000010C_00120011);
    checkFrame("t2", 1'b1, 1'b0);

    // Test 3: overflow of the 16-bit range in both directions
    randomFrame();
    frameData[N] = 16'h7FFF; frameData[N+1] = 16'h8000;
    applyStimulus(1'b1, 32'h200, 2 * N - 1, 1'b0, 1'b1);
    checkFrame("t3a", 1'b1, 1'b0);
    randomFrame();
    frameData[0] = 16'h0001; frameData[1] = 16'hFFFF;
    applyStimulus(1'b0, 32'h200, 2 * N - 1, 1'b0, 1'b1);
`ifdef IMDCT_OLA_SAT_EN
    satWord = 32'h8000_7FFF;
`else
    satWord = 32'h7FFF_8000;
`endif
    checkOutput("t3_sat_word", (gotQ.size() > 0) ? 64'(gotQ[0][31:0]) : 64'hx, 64'(satWord));
    checkFrame("t3b", 1'b1, 1'b0);

    // Test 4: framing errors and recovery
    clearIntr("t4_intr_clr");
    randomFrame();
    applyStimulus(1'b0, 32'h300, 2, 1'b0, 1'b0);
    checkFrame("t4_early_last", 1'b0, 1'b1);
    randomFrame();
    applyStimulus(1'b0, 32'h300, 2 * N - 1, 1'b0, 1'b1);
    checkFrame("t4_recover", 1'b1, 1'b0);
    randomFrame();
    applyStimulus(1'b0, 32'h300, -1, 1'b0, 1'b1);
    checkFrame("t4_missing_last", 1'b1, 1'b1);
    randomFrame();
    applyStimulus(1'b0, 32'h300, 2 * N - 1, 1'b0, 1'b1);
    checkFrame("t4_recover2", 1'b1, 1'b0);

    // Test 5: five frames from a fresh word index, wrap and clear/set collision
    pulseReset();
    for (int f = 0; f < 5; f++) begin
      randomFrame();
      if (f == 4) clearIntr("t5_intr_clr");
      applyStimulus(f == 0, 32'h400, 2 * N - 1, f == 4, 1'b1);
      if (f == 2) begin
        addr0 = (gotQ.size() > 0) ? gotQ[0][63:32] : 32'hx;
        addr1 = (gotQ.size() > 1) ? gotQ[1][63:32] : 32'hx;
        checkOutput("t5_wrap_addr0", 64'(addr0), 64'h400);
        checkOutput("t5_wrap_addr1", 64'(addr1), 64'h404);
      end
      checkFrame($sformatf("t5_f%0d", f), 1'b1, 1'b0);
    end

    // Test 6: asynchronous reset in the middle of a frame
    @(negedge clk_in);
    start = 1'b1; first_frame = 1'b1; base_addr = 32'h600;
    @(negedge clk_in);
    start = 1'b0; first_frame = 1'b0;
    repeat (3) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = 16'($urandom);
      @(negedge clk_in);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ready", 64'(in_ready), 64'd0);
    checkOutput("t6_rst_ena", 64'(bram_ena), 64'd0);
    gotQ.delete();
    refWidx = 0; refTailValid = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    checkOutput("t6_start_ignored", 64'(in_ready), 64'd0);
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = 16'($urandom);
      @(negedge clk_in);
      checkOutput($sformatf("t6_ready_c%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    checkOutput("t6_no_writes", 64'(gotQ.size()), 64'd0);
    checkOutput("t6_intr", 64'(intr), 64'd0);
    randomFrame();
    applyStimulus(1'b0, 32'h600, 2 * N - 1, 1'b0, 1'b1);
    checkFrame("t6_after", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
